// File: rtl/fadd_wave_sequencer_if.sv
// Bundles the operation, adder and result signals of fadd_wave_sequencer.
// The slave modport is the sequencer's view.
// The master modport is the view of the surrounding logic:
// the operand fetch, float_adder_32 and the downstream consumer.
interface fadd_wave_sequencer_if #(
    parameter int LANES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [32*LANES-1:0]   in_a;
    logic [32*LANES-1:0]   in_b;
    logic [LANES-1:0]      in_mask;
    logic                  in_sub;

    logic [31:0]           add_a;
    logic [31:0]           add_b;
    logic [31:0]           add_out;
    logic                  add_nan;
    logic                  add_ovf;

    logic                  out_valid;
    logic                  out_ready;
    logic [32*LANES-1:0]   out_result;
    logic [LANES-1:0]      out_nan_mask;
    logic [LANES-1:0]      out_ovf_mask;
    logic                  out_sticky_nan;
    logic                  out_sticky_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_mask, in_sub,
        output in_ready,
        output add_a, add_b,
        input  add_out, add_nan, add_ovf,
        output out_valid, out_result, out_nan_mask, out_ovf_mask,
        output out_sticky_nan, out_sticky_ovf,
        input  out_ready
    );

    modport master (
        output in_valid, in_a, in_b, in_mask, in_sub,
        input  in_ready,
        input  add_a, add_b,
        output add_out, add_nan, add_ovf,
        input  out_valid, out_result, out_nan_mask, out_ovf_mask,
        input  out_sticky_nan, out_sticky_ovf,
        output out_ready
    );
endinterface

// File: rtl/fadd_wave_sequencer.sv
// fadd_wave_sequencer: accepts one multi-lane FP32 add/sub operation.
// It feeds the lanes one per cycle through a single external
// combinational float_adder_32, then presents the collected vector downstream.
// Optional macro FADD_SKIP_INACTIVE_EN: RUN visits only the lanes enabled by the mask.
// Lanes that are masked off get their pass-through value when the operation is accepted.
module fadd_wave_sequencer #(
    parameter int LANES = 4
) (
    input logic                  clk,
    input logic                  rst,
    fadd_wave_sequencer_if.slave bus
);
    localparam int IDX_W = $clog2(LANES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;

    logic [32*LANES-1:0] op_a_q, op_a_d;
    logic [32*LANES-1:0] op_b_q, op_b_d;
    logic [LANES-1:0]    mask_q, mask_d;
    logic                sub_q, sub_d;

    logic [32*LANES-1:0] result_q, result_d;
    logic [LANES-1:0]    nan_q, nan_d;
    logic [LANES-1:0]    ovf_q, ovf_d;

    logic                accept;
    int                  lane_sel;

    assign accept   = (state_q == IDLE) && bus.in_valid;
    assign lane_sel = int'(idx_q);

`ifdef FADD_SKIP_INACTIVE_EN
    logic [IDX_W-1:0]    first_idx;
    logic                first_found;
    logic [IDX_W-1:0]    next_idx;
    logic                next_found;

    // Finds the lowest active lane of an incoming mask.
    // Also finds the next active lane above the current index.
    always_comb begin
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;
        for (int j = LANES - 1; j >= 0; j--) begin
            if (bus.in_mask[j]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(j);
            end
            if (mask_q[j] && (j > lane_sel)) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(j);
            end
        end
    end
`endif

    // State and lane index registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state logic: walk the lanes in RUN, then wait in DONE for the consumer.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
`ifdef FADD_SKIP_INACTIVE_EN
                    if (first_found) begin
                        state_d = RUN;
                        idx_d   = first_idx;
                    end else begin
                        state_d = DONE;
                        idx_d   = '0;
                    end
`else
                    state_d = RUN;
                    idx_d   = '0;
`endif
                end
            end
            RUN: begin
`ifdef FADD_SKIP_INACTIVE_EN
                if (next_found) begin
                    idx_d = next_idx;
                end else begin
                    state_d = DONE;
                    idx_d   = '0;
                end
`else
                if (idx_q == IDX_W'(LANES - 1)) begin
                    state_d = DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Operand capture and result buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            mask_q   <= '0;
            sub_q    <= 1'b0;
            result_q <= '0;
            nan_q    <= '0;
            ovf_q    <= '0;
        end else begin
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            mask_q   <= mask_d;
            sub_q    <= sub_d;
            result_q <= result_d;
            nan_q    <= nan_d;
            ovf_q    <= ovf_d;
        end
    end

    // Capture operands on accept; fill one result lane per RUN cycle.
    always_comb begin
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        mask_d   = mask_q;
        sub_d    = sub_q;
        result_d = result_q;
        nan_d    = nan_q;
        ovf_d    = ovf_q;
        if (accept) begin
            op_a_d   = bus.in_a;
            op_b_d   = bus.in_b;
            mask_d   = bus.in_mask;
            sub_d    = bus.in_sub;
            result_d = '0;
            nan_d    = '0;
            ovf_d    = '0;
`ifdef FADD_SKIP_INACTIVE_EN
            for (int j = 0; j < LANES; j++) begin
                if (!bus.in_mask[j]) begin
                    result_d[j*32 +: 32] = bus.in_a[j*32 +: 32];
                end
            end
`endif
        end else if (state_q == RUN) begin
            if (mask_q[idx_q]) begin
                result_d[lane_sel*32 +: 32] = bus.add_out;
                nan_d[idx_q]                = bus.add_nan;
                ovf_d[idx_q]                = bus.add_ovf;
            end else begin
                result_d[lane_sel*32 +: 32] = op_a_q[lane_sel*32 +: 32];
                nan_d[idx_q]                = 1'b0;
                ovf_d[idx_q]                = 1'b0;
            end
        end
    end

    // Handshake and adder-operand outputs decoded from the current state.
    // The B sign bit is flipped for subtraction.
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.add_a     = '0;
        bus.add_b     = '0;
        if (state_q == RUN) begin
            bus.add_a = op_a_q[lane_sel*32 +: 32];
            bus.add_b = op_b_q[lane_sel*32 +: 32] ^ {sub_q, 31'b0};
        end
    end

    assign bus.out_result     = result_q;
    assign bus.out_nan_mask   = nan_q;
    assign bus.out_ovf_mask   = ovf_q;
    assign bus.out_sticky_nan = |nan_q;
    assign bus.out_sticky_ovf = |ovf_q;

endmodule

// File: doc/fadd_wave_sequencer.md
Name: fadd_wave_sequencer

Overview:
Sits between the vector-ALU operand fetch and the combinational float_adder_32, which is instantiated outside this block. It accepts one multi-lane FP32 add/sub operation per handshake and drives the lanes through the single adder one per cycle. It captures each lane's sum and NaN/overflow flags into a result buffer, then presents the whole vector downstream with a valid/ready handshake.

Parameters:
LANES, 4, lanes per operation; must be 2 or more.
IDX_W, $clog2(LANES), lane-index width; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  upstream operation valid.
in_ready  out  1  block can accept an operation.
in_a  in  32*LANES  operand A; lane i is bits [32i+31:32i].
in_b  in  32*LANES  operand B; same lane packing as in_a.
in_mask  in  LANES  exec mask; 1 = lane active.
in_sub  in  1  1 = compute A-B by flipping the sign of B.
add_a  out  32  to float_adder_32 A.
add_b  out  32  to float_adder_32 B.
add_out  in  32  from float_adder_32 out; combinational, same cycle.
add_nan  in  1  from float_adder_32 NaN_flag.
add_ovf  in  1  from float_adder_32 overflow_flag.
out_valid  out  1  result vector valid.
out_ready  in  1  downstream accepts.
out_result  out  32*LANES  per-lane results.
out_nan_mask  out  LANES  per-lane NaN flags.
out_ovf_mask  out  LANES  per-lane overflow flags.
out_sticky_nan  out  1  OR of out_nan_mask.
out_sticky_ovf  out  1  OR of out_ovf_mask.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, lane index=0.
  - out_valid=0; out_result, masks and sticky flags all 0.
  - add_a=add_b=0.
  - in_ready is forced 0 while rst is high.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid at an edge: register in_a, in_b, in_mask and in_sub; clear the result buffer, masks and sticky flags; idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - add_a = A lane idx.
  - add_b = B lane idx, with bit 31 inverted when sub=1.
  - At each edge:
    - Active lane: result[idx]=add_out, nan[idx]=add_nan, ovf[idx]=add_ovf.
    - Inactive lane: result[idx]=A lane idx unchanged; both flags 0.
  - idx increments each edge. When idx==LANES-1 the state goes to DONE and idx wraps to 0.
- DONE:
  - out_valid=1.
  - Outputs hold stable until out_ready.
  - On out_ready the state goes to IDLE. No accept occurs in the same cycle: in_ready is 0 in DONE.
- Latency: out_valid rises exactly LANES cycles after the accepting edge. Throughput is one operation per LANES+2 cycles when out_ready is held high.
- add_a/add_b are 0 outside RUN.
- Sticky outputs are the OR-reduction of the registered masks.
- Backpressure: out_ready low holds DONE indefinitely with no output change.
- Reset mid-RUN or mid-DONE aborts the operation; no partial result is ever presented.
- in_valid while in RUN or DONE is ignored. Upstream must hold it until in_ready.

Optional Feature:
Macro: FADD_SKIP_INACTIVE_EN.
- Defined:
  - RUN visits only active lanes. idx advances to the next set mask bit; inactive lanes get their pass-through and zero flags at accept.
  - An all-zero mask goes IDLE->DONE directly, so out_valid is seen 1 cycle after accept.
  - Latency = popcount(mask) cycles, minimum 1.
- Undefined: fixed LANES-cycle RUN as above.

Test Plan:
1. LANES=4, in_a all lanes 0x3F800000, in_b all lanes 0x40000000, mask=4'b1111, sub=0 -> out_valid 4 cycles after accept; all lanes 0x40400000; flag masks 0.
2. Lane 1: A=0x7F800000, B=0xFF800000 (others 1.0+2.0) -> out_nan_mask=4'b0010, out_sticky_nan=1, other lanes 0x40400000.
3. Lane 2: A=B=0x7F7FFFFF -> out_ovf_mask=4'b0100, out_sticky_ovf=1.
4. mask=4'b0101, A lanes distinct (0x3F800000, 0x11111111, 0x3F800000, 0x22222222), B=2.0 -> lanes 0,2 = 0x40400000; lanes 1,3 = A unchanged. With FADD_SKIP_INACTIVE_EN, out_valid after 2 cycles.
5. sub=1, A=0x40400000, B=0x3F800000 all lanes -> every lane 0x40000000. Hold out_ready=0 for 5 cycles -> outputs stable and in_ready=0; after out_ready, in_ready=1 in the next cycle.
6. Assert rst during RUN at idx=2 -> out_valid=0, outputs 0, in_ready=0 while rst high. After release, a new operation completes correctly.
